// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter: FSM encoding,
// default parameter values and a byte-lane helper.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StGrantIf = 2'd1,
        StGrantDm = 2'd2
    } arb_state_e;

    localparam logic [31:0] DEF_DATA_BASE      = 32'h0000_1000;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 16;

    function automatic logic [3:0] lane_onehot(input logic [1:0] lane);
        lane_onehot = 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two CPU requesters, the arbiter and the memory.
// master is the arbiter's view; slave is the surrounding CPU/memory view.
interface mem_arbiter_if;

    logic        if_read;
    logic [31:0] if_address;
    logic [31:0] if_readdata;
    logic        if_busywait;

    logic        dm_read;
    logic        dm_write;
    logic [7:0]  dm_address;
    logic [7:0]  dm_writedata;
    logic [7:0]  dm_readdata;
    logic        dm_busywait;

    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_writedata;
    logic [3:0]  mem_byteen;
    logic [31:0] mem_readdata;
    logic        mem_ack;

    logic        err;

    modport master (
        input  if_read, if_address, dm_read, dm_write, dm_address, dm_writedata,
               mem_readdata, mem_ack,
        output if_readdata, if_busywait, dm_readdata, dm_busywait,
               mem_read, mem_write, mem_address, mem_writedata, mem_byteen, err
    );

    modport slave (
        output if_read, if_address, dm_read, dm_write, dm_address, dm_writedata,
               mem_readdata, mem_ack,
        input  if_readdata, if_busywait, dm_readdata, dm_busywait,
               mem_read, mem_write, mem_address, mem_writedata, mem_byteen, err
    );

endinterface

// File: rtl/mem_arbiter_byte_lane_select.sv
// Byte-lane steering for the 8-bit data port on the 32-bit memory bus:
// lane enable, write-byte replication and read-byte extraction.
module byte_lane_select
    import mem_arbiter_pkg::*;
(
    input  logic [1:0]  i_lane,
    input  logic [7:0]  i_wbyte,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_byteen,
    output logic [31:0] o_wword,
    output logic [7:0]  o_rbyte
);

    always_comb begin
        o_byteen = lane_onehot(i_lane);
        o_wword  = {4{i_wbyte}};
        o_rbyte  = 8'h00;
        unique case (i_lane)
            2'd0: o_rbyte = i_rword[7:0];
            2'd1: o_rbyte = i_rword[15:8];
            2'd2: o_rbyte = i_rword[23:16];
            2'd3: o_rbyte = i_rword[31:24];
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and
// byte-wide data accesses, with a grant timeout that raises a sticky error.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter logic [31:0] DATA_BASE      = DEF_DATA_BASE,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    mem_arbiter_if.master io_bus
);

    localparam int unsigned CNT_W =
        ($clog2(TIMEOUT_CYCLES + 1) > 5) ? $clog2(TIMEOUT_CYCLES + 1) : 5;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_e       r_state;
    arb_state_e       w_state_next;
    logic             r_prio_dm;
    logic [CNT_W-1:0] r_cnt;
    logic             r_if_done;
    logic             r_dm_done;
    logic             r_err;
    logic [31:0]      r_if_rdata;
    logic [7:0]       r_dm_rdata;

    logic        w_if_req;
    logic        w_dm_req;
    logic        w_if_elig;
    logic        w_dm_elig;
    logic        w_dm_is_write;
    logic        w_in_grant;
    logic        w_complete;
    logic        w_timeout;
    logic [31:0] w_dm_addr;
    logic [3:0]  w_lane_byteen;
    logic [31:0] w_lane_wword;
    logic [7:0]  w_lane_rbyte;

    assign w_if_req      = io_bus.if_read;
    assign w_dm_req      = io_bus.dm_read | io_bus.dm_write;
    // A requester is blind to arbitration during its done cycle.
    assign w_if_elig     = w_if_req & ~r_if_done;
    assign w_dm_elig     = w_dm_req & ~r_dm_done;
    assign w_dm_is_write = io_bus.dm_write;
    assign w_dm_addr     = DATA_BASE + {24'b0, io_bus.dm_address};

    assign w_in_grant = (r_state == StGrantIf) || (r_state == StGrantDm);
    assign w_timeout  = w_in_grant && !io_bus.mem_ack && (r_cnt == CNT_LAST);
    assign w_complete = w_in_grant && (io_bus.mem_ack || (r_cnt == CNT_LAST));

    assign io_bus.if_busywait = w_if_elig;
    assign io_bus.dm_busywait = w_dm_elig;
    assign io_bus.if_readdata = r_if_rdata;
    assign io_bus.dm_readdata = r_dm_rdata;
    assign io_bus.err         = r_err;

    byte_lane_select u_lane (
        .i_lane   (io_bus.dm_address[1:0]),
        .i_wbyte  (io_bus.dm_writedata),
        .i_rword  (io_bus.mem_readdata),
        .o_byteen (w_lane_byteen),
        .o_wword  (w_lane_wword),
        .o_rbyte  (w_lane_rbyte)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next         = r_state;
        io_bus.mem_read      = 1'b0;
        io_bus.mem_write     = 1'b0;
        io_bus.mem_address   = 32'h0;
        io_bus.mem_writedata = 32'h0;
        io_bus.mem_byteen    = 4'h0;
        case (r_state)
            StIdle: begin
                if (w_if_elig && w_dm_elig) begin
                    w_state_next = r_prio_dm ? StGrantDm : StGrantIf;
                end else if (w_dm_elig) begin
                    w_state_next = StGrantDm;
                end else if (w_if_elig) begin
                    w_state_next = StGrantIf;
                end
            end
            StGrantIf: begin
                io_bus.mem_read    = 1'b1;
                io_bus.mem_address = io_bus.if_address;
                io_bus.mem_byteen  = 4'hF;
                if (w_complete) begin
                    w_state_next = w_dm_elig ? StGrantDm : StIdle;
                end
            end
            StGrantDm: begin
                io_bus.mem_write     = w_dm_is_write;
                io_bus.mem_read      = !w_dm_is_write;
                io_bus.mem_address   = w_dm_addr;
                io_bus.mem_writedata = w_lane_wword;
                io_bus.mem_byteen    = w_lane_byteen;
                if (w_complete) begin
                    w_state_next = w_if_elig ? StGrantIf : StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_prio_dm  <= 1'b1;
            r_cnt      <= '0;
            r_if_done  <= 1'b0;
            r_dm_done  <= 1'b0;
            r_err      <= 1'b0;
            r_if_rdata <= 32'h0;
            r_dm_rdata <= 8'h0;
        end else begin
            r_if_done <= w_complete && (r_state == StGrantIf);
            r_dm_done <= w_complete && (r_state == StGrantDm);
            if (w_complete) begin
                r_cnt     <= '0;
                r_prio_dm <= (r_state == StGrantIf);
            end else if (w_in_grant) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
            if (w_complete && (r_state == StGrantIf)) begin
                r_if_rdata <= w_timeout ? 32'h0 : io_bus.mem_readdata;
            end
            if (w_complete && (r_state == StGrantDm) && !w_dm_is_write) begin
                r_dm_rdata <= w_timeout ? 8'h0 : w_lane_rbyte;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch and data accesses, round-robin order,
// timeout error and reset in the middle of a grant.
module tb_mem_arbiter;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fails;

    mem_arbiter_if bus ();

    mem_arbiter #(
        .DATA_BASE      (32'h0000_1000),
        .TIMEOUT_CYCLES (16)
    ) u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        bus.if_read      = 1'b0;
        bus.if_address   = 32'h0;
        bus.dm_read      = 1'b0;
        bus.dm_write     = 1'b0;
        bus.dm_address   = 8'h0;
        bus.dm_writedata = 8'h0;
        bus.mem_readdata = 32'h0;
        bus.mem_ack      = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        idle_inputs();
        tick();
        tick();
        rst_n = 1'b1;
        settle();
    endtask

    // 0 = no grant, 1 = fetch grant, 2 = data grant
    function automatic logic [31:0] grant_code();
        if (!(bus.mem_read || bus.mem_write)) return 32'd0;
        return (bus.mem_byteen == 4'hF) ? 32'd1 : 32'd2;
    endfunction

    int rr_exp [6] = '{1, 2, 0, 1, 2, 0};

    initial begin
        int busy;
        int n;
        n_checks = 0;
        n_fails  = 0;
        rst_n    = 1'b0;
        idle_inputs();

        // Reset state
        apply_reset();
        check_eq("rst_mem_read", bus.mem_read, 0);
        check_eq("rst_mem_write", bus.mem_write, 0);
        check_eq("rst_mem_addr", bus.mem_address, 0);
        check_eq("rst_byteen", bus.mem_byteen, 0);
        check_eq("rst_wdata", bus.mem_writedata, 0);
        check_eq("rst_err", bus.err, 0);
        check_eq("rst_if_rdata", bus.if_readdata, 0);
        check_eq("rst_dm_rdata", bus.dm_readdata, 0);

        // Lone fetch, ACK in the third grant cycle
        bus.if_read    = 1'b1;
        bus.if_address = 32'h0000_0004;
        settle();
        busy = 0;
        for (int c = 0; c < 12; c++) begin
            if (!bus.if_busywait) break;
            busy++;
            if (c == 1) begin
                check_eq("if_mem_read", bus.mem_read, 1);
                check_eq("if_mem_addr", bus.mem_address, 32'h0000_0004);
                check_eq("if_byteen", bus.mem_byteen, 4'hF);
            end
            bus.mem_ack      = (c == 3);
            bus.mem_readdata = (c == 3) ? 32'h0102_0304 : 32'h0;
            tick();
        end
        bus.mem_ack = 1'b0;
        check_eq("if_busy_cycles", busy, 4);
        check_eq("if_rdata", bus.if_readdata, 32'h0102_0304);
        check_eq("if_err", bus.err, 0);
        bus.if_read = 1'b0;

        // Simultaneous requests after reset: DM wins first
        apply_reset();
        bus.if_read    = 1'b1;
        bus.if_address = 32'h0000_0040;
        bus.dm_read    = 1'b1;
        bus.dm_address = 8'h05;
        settle();
        check_eq("both_if_busy", bus.if_busywait, 1);
        check_eq("both_dm_busy", bus.dm_busywait, 1);
        tick();
        check_eq("dm1_mem_read", bus.mem_read, 1);
        check_eq("dm1_mem_addr", bus.mem_address, 32'h0000_1005);
        check_eq("dm1_byteen", bus.mem_byteen, 4'b0010);
        bus.mem_ack      = 1'b1;
        bus.mem_readdata = 32'h1122_3344;
        tick();
        check_eq("if2_mem_addr", bus.mem_address, 32'h0000_0040);
        check_eq("if2_byteen", bus.mem_byteen, 4'hF);
        check_eq("dm1_busy_low", bus.dm_busywait, 0);
        check_eq("dm1_rdata", bus.dm_readdata, 8'h33);
        check_eq("if2_busy", bus.if_busywait, 1);
        bus.dm_read      = 1'b0;
        bus.mem_readdata = 32'hCAFE_BABE;
        tick();
        check_eq("if2_busy_low", bus.if_busywait, 0);
        check_eq("if2_rdata", bus.if_readdata, 32'hCAFE_BABE);
        check_eq("idle_mem_addr", bus.mem_address, 0);
        bus.if_read = 1'b0;
        bus.mem_ack = 1'b0;

        // Read+write together is a write; byte lane 3
        bus.dm_read      = 1'b1;
        bus.dm_write     = 1'b1;
        bus.dm_address   = 8'h03;
        bus.dm_writedata = 8'hAB;
        tick();
        check_eq("wr_mem_write", bus.mem_write, 1);
        check_eq("wr_mem_read", bus.mem_read, 0);
        check_eq("wr_byteen", bus.mem_byteen, 4'b1000);
        check_eq("wr_wdata", bus.mem_writedata, 32'hABAB_ABAB);
        check_eq("wr_mem_addr", bus.mem_address, 32'h0000_1003);
        bus.mem_ack      = 1'b1;
        bus.mem_readdata = 32'hDEAD_BEEF;
        tick();
        check_eq("wr_busy_low", bus.dm_busywait, 0);
        check_eq("wr_rdata_kept", bus.dm_readdata, 8'h33);
        bus.dm_read  = 1'b0;
        bus.dm_write = 1'b0;
        bus.mem_ack  = 1'b0;

        // Continuous demand with ACK held: IF, DM, idle, IF, DM, idle
        bus.if_read      = 1'b1;
        bus.if_address   = 32'h0000_0080;
        bus.dm_read      = 1'b1;
        bus.dm_address   = 8'h02;
        bus.mem_ack      = 1'b1;
        bus.mem_readdata = 32'h5555_AAAA;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_eq($sformatf("rr_grant%0d", i), grant_code(), rr_exp[i]);
        end
        bus.if_read = 1'b0;
        bus.dm_read = 1'b0;
        bus.mem_ack = 1'b0;
        check_eq("rr_if_rdata", bus.if_readdata, 32'h5555_AAAA);
        check_eq("rr_dm_rdata", bus.dm_readdata, 8'h55);
        tick();

        // Timeout on a fetch: 16 grant cycles, data 0, sticky error
        bus.if_read    = 1'b1;
        bus.if_address = 32'h0000_0100;
        tick();
        check_eq("to_err_before", bus.err, 0);
        n = 0;
        while (bus.mem_read && n < 40) begin
            n++;
            tick();
        end
        check_eq("to_grant_cycles", n, 16);
        check_eq("to_busy_low", bus.if_busywait, 0);
        check_eq("to_if_rdata", bus.if_readdata, 0);
        check_eq("to_err_set", bus.err, 1);
        bus.if_read = 1'b0;
        tick();
        tick();
        tick();
        check_eq("to_err_sticky", bus.err, 1);
        apply_reset();
        check_eq("to_err_cleared", bus.err, 0);

        // Reset in the middle of a data grant, then a stray ACK
        bus.dm_read      = 1'b1;
        bus.dm_address   = 8'h01;
        bus.mem_readdata = 32'h0000_AB00;
        tick();
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        check_eq("pre_dm_rdata", bus.dm_readdata, 8'hAB);
        bus.dm_read = 1'b0;
        tick();
        bus.dm_read    = 1'b1;
        bus.dm_address = 8'h07;
        tick();
        check_eq("mid_grant", bus.mem_read, 1);
        rst_n = 1'b0;
        tick();
        rst_n            = 1'b1;
        bus.mem_ack      = 1'b1;
        bus.mem_readdata = 32'hFFFF_FFFF;
        settle();
        check_eq("abort_idle", bus.mem_read, 0);
        check_eq("abort_dm_rdata", bus.dm_readdata, 0);
        check_eq("abort_busy", bus.dm_busywait, 1);
        bus.mem_ack = 1'b0;
        tick();
        check_eq("stray_no_done", bus.dm_busywait, 1);
        check_eq("stray_rdata", bus.dm_readdata, 0);
        check_eq("regrant", bus.mem_read, 1);
        bus.mem_ack = 1'b1;
        tick();
        check_eq("regrant_rdata", bus.dm_readdata, 8'hFF);
        bus.mem_ack = 1'b0;
        bus.dm_read = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_BASE, default 32'h0000_1000, byte offset added to data-port addresses.
REQ-002 Parameter TIMEOUT_CYCLES, default 16, maximum grant-state cycles awaiting MEM_ACK.
REQ-003 CLK  in  1  single clock; all state updates on rising edge.
REQ-004 RESET  in  1  synchronous, active-low reset.
REQ-005 IF_READ  in  1  instruction-fetch request; IF_ADDRESS  in  32  byte address.
REQ-006 IF_READDATA  out  32  fetched word; IF_BUSYWAIT  out  1  fetch stall.
REQ-007 DM_READ, DM_WRITE  in  1 each  data load/store request; DM_ADDRESS  in  8; DM_WRITEDATA  in  8.
REQ-008 DM_READDATA  out  8  loaded byte; DM_BUSYWAIT  out  1  data stall.
REQ-009 MEM_READ, MEM_WRITE  out  1 each; MEM_ADDRESS  out  32; MEM_WRITEDATA  out  32; MEM_BYTEEN  out  4.
REQ-010 MEM_READDATA  in  32; MEM_ACK  in  1  one-cycle completion pulse from memory.
REQ-011 ERR  out  1  sticky timeout flag.

Function
REQ-012 States SHALL be IDLE, GRANT_IF, GRANT_DM.
REQ-013 X_BUSYWAIT SHALL equal X request AND NOT X_done, combinationally, for X in {IF, DM}; DM request = DM_READ OR DM_WRITE.
REQ-014 X_done SHALL be registered, high exactly one cycle following completion of X's access; requests of X are ignored for arbitration while X_done is high.
REQ-015 In IDLE, eligible requests SHALL be sampled; next state is GRANT of the winner; none eligible stays IDLE.
REQ-016 Arbitration SHALL be round-robin: a one-bit pointer favours DM after reset and flips to the other requester after each completion.
REQ-017 In GRANT_IF: MEM_READ=1, MEM_WRITE=0, MEM_ADDRESS=IF_ADDRESS, MEM_BYTEEN=4'hF.
REQ-018 In GRANT_DM: MEM_ADDRESS=DATA_BASE+{24'b0,DM_ADDRESS} (modulo 2^32); MEM_BYTEEN one-hot at bit DM_ADDRESS[1:0]; MEM_WRITEDATA = DM_WRITEDATA replicated to 4 lanes.
REQ-019 DM_READ and DM_WRITE both high SHALL be treated as a write.
REQ-020 Outside grant states MEM_READ, MEM_WRITE SHALL be 0; MEM_ADDRESS, MEM_WRITEDATA, MEM_BYTEEN 0.
REQ-021 MEM_ACK SHALL be honoured only in grant states; in IDLE it is ignored.
REQ-022 On ACK in GRANT_IF, IF_READDATA SHALL register MEM_READDATA; in GRANT_DM read, DM_READDATA registers byte lane DM_ADDRESS[1:0]; write leaves DM_READDATA unchanged.
REQ-023 On ACK, next state SHALL be GRANT of the other requester if it is eligible, else IDLE (no idle bubble).
REQ-024 A 5-bit-minimum counter SHALL count grant-state cycles; reaching TIMEOUT_CYCLES without ACK completes the access with read data 0 and sets ERR.
REQ-025 Minimum stall: request in cycle n, grant n+1, ACK n+1, BUSYWAIT low in n+2.
REQ-026 Requesters SHALL hold request, address, write data stable while BUSYWAIT is high; arbiter does not latch them.

Reset
REQ-027 With RESET low at an edge: state IDLE, pointer DM, counter 0, both done flags 0, ERR 0, IF_READDATA 0, DM_READDATA 0.
REQ-028 Reset mid-grant SHALL abort the access; a subsequent stray ACK is ignored per REQ-021.

Structure
REQ-029 State encoding and the default parameter values SHALL live in the shared CPU package.
REQ-030 Byte-lane selection/replication SHALL be one combinational sub-module, byte_lane_select.

Verification
REQ-031 IF_READ alone, IF_ADDRESS=32'h0000_0004, ACK after 3 cycles with 32'h0102_0304 -> IF_BUSYWAIT high 4 cycles, IF_READDATA=32'h0102_0304, ERR 0.
REQ-032 IF_READ and DM_READ same cycle after reset, DM_ADDRESS=8'h05 -> DM first at MEM_ADDRESS 32'h0000_1005, BYTEEN 4'b0010; IF granted the cycle after DM ACK.
REQ-033 DM_WRITE, DM_ADDRESS=8'h03, DM_WRITEDATA=8'hAB -> MEM_WRITE=1, BYTEEN 4'b1000, MEM_WRITEDATA 32'hABAB_ABAB.
REQ-034 Grant with no ACK for 16 cycles -> access completes, read data 0, ERR=1 and stays 1 until reset.
REQ-035 RESET low during GRANT_DM, ACK pulsed next cycle -> state IDLE, DM_READDATA 0, no done pulse.
REQ-036 Requests held through done cycle -> same request not re-serviced; round-robin alternates IF/DM on continuous demand.
